// File: rtl/operand_fetch.sv
// Operand fetch stage: single-entry skid-free pipeline register between decode and execute.
// Optional writeback bypass and held-entry snooping enabled with `define OPERAND_BYPASS_EN.
module operand_fetch #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_imm,
  input  logic [7:0]      in_ctrl,
  output logic [AW-1:0]   rf_rd_addr1,
  output logic [AW-1:0]   rf_rd_addr2,
  input  logic [XLEN-1:0] rf_rd_data1,
  input  logic [XLEN-1:0] rf_rd_data2,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_rd,
  output logic [7:0]      out_ctrl,
  output logic [15:0]     stall_cnt
);

  logic            vld_p0;
  logic [XLEN-1:0] op1_p0;
  logic [XLEN-1:0] op2_p0;
  logic [XLEN-1:0] imm_p0;
  logic [AW-1:0]   rd_p0;
  logic [7:0]      ctrl_p0;
  logic [AW-1:0]   rs1_p0;
  logic [AW-1:0]   rs2_p0;
  logic [15:0]     stall_p0;
  logic            capture;
  logic            stall;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

`ifdef OPERAND_BYPASS_EN
  function automatic logic [XLEN-1:0] fetch_operand(input logic [AW-1:0]   rs,
                                                    input logic [XLEN-1:0] rf_data);
    if (rs == '0)
      return '0;
    if (wb_en && (wb_addr == rs))
      return wb_data;
    return rf_data;
  endfunction
`else
  function automatic logic [XLEN-1:0] fetch_operand(input logic [AW-1:0]   rs,
                                                    input logic [XLEN-1:0] rf_data);
    return (rs == '0) ? '0 : rf_data;
  endfunction

  // Writeback port and held source numbers only matter when bypassing is built in.
  logic unused_bypass;
  assign unused_bypass = ^{wb_en, wb_addr, wb_data, rs1_p0, rs2_p0};
`endif

  assign rf_rd_addr1 = in_rs1;
  assign rf_rd_addr2 = in_rs2;
  assign in_ready    = !vld_p0 || out_ready;
  assign capture     = in_valid && in_ready && !flush;
  assign stall       = vld_p0 && !out_ready;

  // Stage p0: held entry presented to execute
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0   <= 1'b0;
      op1_p0   <= '0;
      op2_p0   <= '0;
      imm_p0   <= '0;
      rd_p0    <= '0;
      ctrl_p0  <= '0;
      rs1_p0   <= '0;
      rs2_p0   <= '0;
      stall_p0 <= '0;
    end else begin
      if (flush) begin
        vld_p0 <= 1'b0;
      end else if (capture) begin
        vld_p0  <= 1'b1;
        op1_p0  <= fetch_operand(in_rs1, rf_rd_data1);
        op2_p0  <= fetch_operand(in_rs2, rf_rd_data2);
        imm_p0  <= in_imm;
        rd_p0   <= in_rd;
        ctrl_p0 <= in_ctrl;
        rs1_p0  <= in_rs1;
        rs2_p0  <= in_rs2;
      end else if (vld_p0 && out_ready) begin
        vld_p0 <= 1'b0;
      end
`ifdef OPERAND_BYPASS_EN
      // A stalled entry must not miss a writeback to one of its sources.
      if (stall && !flush) begin
        if (wb_en && (wb_addr == rs1_p0) && (rs1_p0 != '0))
          op1_p0 <= wb_data;
        if (wb_en && (wb_addr == rs2_p0) && (rs2_p0 != '0))
          op2_p0 <= wb_data;
      end
`endif
      if (stall && !flush)
        stall_p0 <= sat_inc(stall_p0);
    end
  end

  assign out_valid = vld_p0;
  assign out_op1   = op1_p0;
  assign out_op2   = op2_p0;
  assign out_imm   = imm_p0;
  assign out_rd    = rd_p0;
  assign out_ctrl  = ctrl_p0;
  assign stall_cnt = stall_p0;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: queue-based reference model plus directed scenarios and random traffic.
module tb_operand_fetch;

`ifdef OPERAND_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic [7:0]  in_ctrl;
  logic [4:0]  rf_rd_addr1, rf_rd_addr2;
  logic [31:0] rf_rd_data1, rf_rd_data2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1, out_op2, out_imm;
  logic [4:0]  out_rd;
  logic [7:0]  out_ctrl;
  logic [15:0] stall_cnt;

  operand_fetch #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
    .out_rd(out_rd), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [7:0]  ctrl;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned m_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT state against the model; retires the entry on a handshake.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    chk("in_ready", 32'(in_ready), 32'((q.size() == 0) || out_ready));
    chk("rf_rd_addr1", 32'(rf_rd_addr1), 32'(in_rs1));
    chk("rf_rd_addr2", 32'(rf_rd_addr2), 32'(in_rs2));
    if (out_valid && q.size() != 0) begin
      chk("out_op1", out_op1, q[0].op1);
      chk("out_op2", out_op2, q[0].op2);
      chk("out_imm", out_imm, q[0].imm);
      chk("out_rd", 32'(out_rd), 32'(q[0].rd));
      chk("out_ctrl", 32'(out_ctrl), 32'(q[0].ctrl));
      if (out_ready && !flush && reset)
        void'(q.pop_front());
    end
  end

  function automatic logic [31:0] expect_op(input logic [4:0] rs, input logic [31:0] d,
                                           input logic we, input logic [4:0] wa,
                                           input logic [31:0] wd);
    if (rs == 5'd0) return 32'd0;
    if (BYP && we && wa == rs) return wd;
    return d;
  endfunction

  // Drives one cycle of inputs, waits for the edge, then advances the model.
  task automatic step(input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic [31:0] imm, input logic [7:0] ctl,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic fl, input logic ordy);
    logic was_valid;
    logic rst_edge;
    ent_t e;
    in_valid = iv; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_imm = imm; in_ctrl = ctl;
    rf_rd_data1 = d1; rf_rd_data2 = d2;
    wb_en = we; wb_addr = wa; wb_data = wd; flush = fl; out_ready = ordy;
    was_valid = (q.size() != 0);
    @(posedge clk);
    rst_edge = reset;
    #1;
    if (!rst_edge) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (fl && was_valid && q.size() != 0)
        void'(q.pop_back());
      if (was_valid && !ordy && !fl) begin
        if (m_cnt < 32'hFFFF) m_cnt++;
        if (BYP && we && q.size() != 0) begin
          e = q[0];
          if (wa == e.rs1 && e.rs1 != 5'd0) e.op1 = wd;
          if (wa == e.rs2 && e.rs2 != 5'd0) e.op2 = wd;
          q[0] = e;
        end
      end
      if (iv && (!was_valid || ordy) && !fl) begin
        e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.imm = imm; e.ctrl = ctl;
        e.op1 = expect_op(r1, d1, we, wa, wd);
        e.op2 = expect_op(r2, d2, we, wa, wd);
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 8'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, ordy);
  endtask

  task automatic rnd_step();
    step(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
         $urandom, 8'($urandom), $urandom, $urandom,
         1'($urandom), 5'($urandom_range(0, 3)), $urandom,
         1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7));
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_imm = 0; in_ctrl = 0;
    rf_rd_data1 = 0; rf_rd_data2 = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    flush = 0; out_ready = 0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_op1", out_op1, 32'd0);
    chk("reset_op2", out_op2, 32'd0);
    chk("reset_imm", out_imm, 32'd0);
    chk("reset_rd", 32'(out_rd), 32'd0);
    chk("reset_ctrl", 32'(out_ctrl), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk); #2;
    idle(1'b1);
    idle(1'b1);
    reset = 1'b1;

    // Basic capture with x0 on rs2
    step(1'b1, 5'd3, 5'd0, 5'd9, 32'h1234, 8'h5A, 32'h11, 32'hFF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_op1", out_op1, 32'h11);
    chk("basic_op2", out_op2, 32'd0);
    idle(1'b1);

    // Capture-time bypass
    step(1'b1, 5'd5, 5'd6, 5'd1, 32'd0, 8'd0, 32'hA, 32'h3, 1'b1, 5'd5, 32'hB, 1'b0, 1'b1);
    chk("bypass_op1", out_op1, BYP ? 32'hB : 32'hA);
    idle(1'b1);

    reset = 1'b0;
    #1;
    q.delete();
    m_cnt = 0;
    #1;
    reset = 1'b1;

    // Three stall cycles with a snoopable writeback on the second
    step(1'b1, 5'd1, 5'd7, 5'd2, 32'h5, 8'h1, 32'h10, 32'h70, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 5'd2, 5'd3, 5'd4, 32'h6, 8'h2, 32'h20, 32'h30, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("stall_in_ready_1", 32'(in_ready), 32'd0);
    step(1'b1, 5'd2, 5'd3, 5'd4, 32'h6, 8'h2, 32'h20, 32'h30, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0);
    chk("stall_in_ready_2", 32'(in_ready), 32'd0);
    step(1'b1, 5'd2, 5'd3, 5'd4, 32'h6, 8'h2, 32'h20, 32'h30, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("stall_in_ready_3", 32'(in_ready), 32'd0);
    chk("stall_cnt_3", 32'(stall_cnt), 32'd3);
    chk("snoop_op2", out_op2, BYP ? 32'h77 : 32'h70);

    // Back-to-back stream of four
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'(i + 1), 5'(i + 2), 5'(i), 32'(i * 3), 8'(i), 32'(100 + i), 32'(200 + i),
           1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      chk("stream_op1", out_op1, 32'(100 + i));
    end
    chk("stream_stall_cnt", 32'(stall_cnt), 32'd3);
    idle(1'b1);

    // Flush beats a simultaneous capture and drain
    step(1'b1, 5'd4, 5'd5, 5'd6, 32'h9, 8'h3, 32'h40, 32'h50, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 5'd1, 5'd1, 5'd1, 32'h1, 8'h1, 32'h1, 32'h1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a stall
    step(1'b1, 5'd4, 5'd5, 5'd6, 32'h9, 8'h3, 32'h40, 32'h50, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 8'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("midreset_valid", 32'(out_valid), 32'd0);
    chk("midreset_stall_cnt", 32'(stall_cnt), 32'd0);
    q.delete();
    m_cnt = 0;
    idle(1'b1);
    reset = 1'b1;
    idle(1'b1);
    chk("post_reset_valid", 32'(out_valid), 32'd0);

    repeat (3000) rnd_step();
    idle(1'b1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
